bitrev_buffer: RTL

Parametrised bit-reversal reorder buffer, successor to the fixed four-word bit-reversal wrapper. It accepts a frame of N = 2**LOG2_N samples in natural order and returns them in bit-reversed index order. Write and read strobes are level signals; a rising-edge detector turns each into a one-cycle internal pulse. It sits between the sample source and the FFT butterfly stage, replacing the external reset-counter wrapper with self-contained frame sequencing.

---
 rtl/bitrev_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bitrev_buffer.sv
// Bit-reversal reorder buffer: natural-order frame in, bit-reversed order out.
// Define BITREV_PINGPONG_EN for two banks so loading and readout can overlap.
module bitrev_buffer #(
  parameter int LOG2_N = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              start_flag_i,
  input  logic              write_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              read_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  output logic              done_flag_o,
  output logic              err_o
);

  localparam int N = 2 ** LOG2_N;
`ifdef BITREV_PINGPONG_EN
  localparam int NB = 2;
  localparam int AW = LOG2_N + 1;
`else
  localparam int NB = 1;
  localparam int AW = LOG2_N;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, FULL} wstate_t;

  wstate_t           state, state_n;
  logic [LOG2_N-1:0] wr_cnt, rd_cnt;
  logic [NB-1:0]     full, full_n;
  logic              write_q, read_q;
  logic              wr_p, rd_p, wr_en, rd_en, wr_last, rd_last, start_err;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [DATA_W-1:0] mem [NB*N];

  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] idx);
    for (int b = 0; b < LOG2_N; b++) bitrev[b] = idx[LOG2_N-1-b];
  endfunction

  assign wr_p    = write_i & ~write_q;
  assign rd_p    = read_i & ~read_q;
  assign wr_en   = wr_p && (state == LOAD);
  assign rd_en   = rd_p && done_flag_o;
  assign wr_last = wr_en && (&wr_cnt);
  assign rd_last = rd_en && (&rd_cnt);

`ifdef BITREV_PINGPONG_EN
  logic wbank, rbank;

  assign done_flag_o = full[rbank];
  assign wr_addr     = {wbank, wr_cnt};
  assign rd_addr     = {rbank, bitrev(rd_cnt)};
  // While the writer waits on a full bank a new start is harmless.
  assign start_err   = start_flag_i && (state == LOAD);

  // Last write and last read on one edge always hit different banks.
  always_comb begin
    full_n = full;
    if (wr_last) full_n[wbank] = 1'b1;
    if (rd_last) full_n[rbank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
    end else begin
      if (wr_last) wbank <= ~wbank;
      if (rd_last) rbank <= ~rbank;
    end
  end
`else
  assign done_flag_o = full[0];
  assign wr_addr     = wr_cnt;
  assign rd_addr     = bitrev(rd_cnt);
  assign start_err   = start_flag_i && (state != IDLE);

  always_comb begin
    full_n = full;
    if (wr_last) full_n[0] = 1'b1;
    if (rd_last) full_n[0] = 1'b0;
  end
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start_flag_i) state_n = LOAD;
      LOAD: begin
`ifdef BITREV_PINGPONG_EN
        if (wr_last) state_n = full_n[~wbank] ? FULL : IDLE;
`else
        if (wr_last) state_n = FULL;
`endif
      end
      FULL: begin
`ifdef BITREV_PINGPONG_EN
        if (!full_n[wbank]) state_n = IDLE;
`else
        if (!full_n[0]) state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      full         <= '0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      dout_o       <= '0;
      dout_valid_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      write_q      <= write_i;
      read_q       <= read_i;
      state        <= state_n;
      full         <= full_n;
      dout_valid_o <= rd_en;
      if (state == IDLE && start_flag_i) wr_cnt <= '0;
      else if (wr_en)                    wr_cnt <= wr_cnt + LOG2_N'(1);
      if (rd_en) begin
        rd_cnt <= rd_cnt + LOG2_N'(1);
        dout_o <= mem[rd_addr];
      end
      if ((wr_p && state != LOAD) || (rd_p && !done_flag_o) || start_err)
        err_o <= 1'b1;
    end
  end

  // Sample storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din_i;
  end

endmodule
